// File: rtl/multu_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : multu_unit_if
// Description : Issue/read/status bundle between the pipeline and multu_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface multu_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       alusel;
    logic [WIDTH-1:0] hilo_out;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, a, b, alusel,
        input  hilo_out, hi, lo, busy, done, stall
    );

    modport slave (
        input  start, a, b, alusel,
        output hilo_out, hi, lo, busy, done, stall
    );
endinterface
`default_nettype wire

// File: rtl/multu_unit.sv
`default_nettype none
// ============================================================================
// Module      : multu_unit
// Description : Iterative radix-2 shift-add unsigned multiplier owning HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module multu_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    multu_unit_if.slave       bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_last_step = CW'(WIDTH - 1);
    localparam logic [1:0]    c_sel_hi    = 2'b01;
    localparam logic [1:0]    c_sel_lo    = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH:0]   w_addend;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_p_next;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_hilo;
    logic             w_read_req;

    // P stays below 2^WIDTH after every shift, so the W+1 bit sum never overflows.
    assign w_addend = r_q[0] ? {1'b0, r_m} : '0;
    assign w_sum    = r_p + w_addend;
    assign w_p_next = {1'b0, w_sum[WIDTH:1]};
    assign w_q_next = {w_sum[0], r_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_p     <= '0;
                        r_q     <= bus.b;
                        r_m     <= bus.a;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // start is deliberately ignored here; the pipeline sees stall.
                    r_p     <= w_p_next;
                    r_q     <= w_q_next;
                    r_count <= r_count + CW'(1);
                    if (r_count == c_last_step) begin
                        r_hi    <= w_p_next[WIDTH-1:0];
                        r_lo    <= w_q_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_hilo = '0;
        case (bus.alusel)
            c_sel_hi: w_hilo = r_hi;
            c_sel_lo: w_hilo = r_lo;
            default:  w_hilo = '0;
        endcase
    end

    assign w_read_req   = (bus.alusel == c_sel_hi) || (bus.alusel == c_sel_lo);

    assign bus.hilo_out = w_hilo;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.stall    = r_busy && (bus.start || w_read_req);

endmodule
`default_nettype wire

// File: tb/tb_multu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multu_unit
// Description : Self-checking bench for multu_unit against a 64-bit product model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multu_unit;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    multu_unit_if #(.WIDTH(32)) bus ();

    multu_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
        return 64'(x) * 64'(y);
    endfunction

    function automatic logic [31:0] ref_sel(input logic [1:0] sel, input logic [63:0] p);
        if (sel == 2'b01) return p[63:32];
        if (sel == 2'b10) return p[31:0];
        return 32'h0;
    endfunction

    // Called at a falling edge; returns at the falling edge right after the start edge.
    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Edges from the start edge until done is seen (-1 on timeout), plus busy samples.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (bus.done !== 1'b1 && edges < 100) begin
            if (bus.busy === 1'b1) busy_cycles++;
            @(negedge clk);
            edges++;
        end
        if (edges >= 100) edges = -1;
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus.alusel = 2'b01;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({bus.hi, bus.lo} !== 64'h0) begin
            n_err++; $display("FAIL reset_hilo: got %h want 0", {bus.hi, bus.lo});
        end
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        n_cmp++;
        if (bus.hilo_out !== 32'h0) begin
            n_err++; $display("FAIL reset_hilo_out: got %h want 0", bus.hilo_out);
        end
    endtask

    task automatic run_check(input string name, input logic [31:0] x, input logic [31:0] y);
        int edges, bcyc;
        logic [63:0] exp;
        exp = ref_prod(x, y);
        issue(x, y);
        wait_done(edges, bcyc);
        n_cmp++;
        if (edges != 32 || bcyc != 32) begin
            n_err++; $display("FAIL %s_latency: edges=%0d busy=%0d want 32 32", name, edges, bcyc);
        end
        n_cmp++;
        if ({bus.hi, bus.lo} !== exp) begin
            n_err++; $display("FAIL %s_product: got %h want %h", name, {bus.hi, bus.lo}, exp);
        end
        bus.alusel = 2'($urandom_range(0, 3));
        #1;
        n_cmp++;
        if (bus.hilo_out !== ref_sel(bus.alusel, exp)) begin
            n_err++; $display("FAIL %s_read sel=%b: got %h want %h", name, bus.alusel, bus.hilo_out, ref_sel(bus.alusel, exp));
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL %s_done_pulse: done=%b busy=%b want 0 0", name, bus.done, bus.busy);
        end
    endtask

    task automatic test_small;
        bus.alusel = 2'b10;
        run_check("small", 32'd3, 32'd5);
        bus.alusel = 2'b10;
        #1;
        n_cmp++;
        if (bus.hilo_out !== 32'hF) begin
            n_err++; $display("FAIL small_mflo: got %h want f", bus.hilo_out);
        end
    endtask

    task automatic test_max;
        run_check("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_cmp++;
        if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h1) begin
            n_err++; $display("FAIL max_const: got %h_%h want fffffffe_00000001", bus.hi, bus.lo);
        end
        run_check("msb", 32'h8000_0000, 32'd2);
    endtask

    task automatic test_busy_inputs;
        int edges;
        logic [31:0] x, y;
        logic [63:0] exp, old;
        old = {bus.hi, bus.lo};
        x   = $urandom;
        y   = $urandom;
        exp = ref_prod(x, y);
        bus.alusel = 2'b00;
        issue(x, y);
        edges = 0;
        while (bus.done !== 1'b1 && edges < 100) begin
            if (edges == 10) begin
                bus.a      = ~x;
                bus.b      = y ^ 32'h5A5A_5A5A;
                bus.start  = 1'b1;
                bus.alusel = 2'b01;
                #1;
                n_cmp++;
                if (bus.stall !== 1'b1) begin
                    n_err++; $display("FAIL busy_stall: got %b want 1", bus.stall);
                end
                n_cmp++;
                if (bus.hilo_out !== old[63:32]) begin
                    n_err++; $display("FAIL busy_old_hi: got %h want %h", bus.hilo_out, old[63:32]);
                end
            end
            @(negedge clk);
            bus.start  = 1'b0;
            bus.alusel = 2'b00;
            edges++;
        end
        n_cmp++;
        if (edges != 32) begin
            n_err++; $display("FAIL busy_latency: got %0d want 32", edges);
        end
        n_cmp++;
        if ({bus.hi, bus.lo} !== exp) begin
            n_err++; $display("FAIL busy_product: got %h want %h", {bus.hi, bus.lo}, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int seen;
        issue($urandom, $urandom | 32'h1);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || {bus.hi, bus.lo} !== 64'h0) begin
            n_err++; $display("FAIL rstmid_state: busy=%b hilo=%h want 0 0", bus.busy, {bus.hi, bus.lo});
        end
        seen = 0;
        repeat (40) begin
            if (bus.done === 1'b1) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++; $display("FAIL rstmid_no_done: got %0d pulses want 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        int edges, bcyc;
        issue(32'd3, 32'd5);
        wait_done(edges, bcyc);
        bus.a      = 32'd7;
        bus.b      = 32'd9;
        bus.start  = 1'b1;
        bus.alusel = 2'b10;
        #1;
        n_cmp++;
        if (bus.hilo_out !== 32'd15 || bus.stall !== 1'b0 || edges != 32) begin
            n_err++; $display("FAIL b2b_first: lo=%0d stall=%b edges=%0d want 15 0 32", bus.hilo_out, bus.stall, edges);
        end
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_err++; $display("FAIL b2b_restart: busy=%b done=%b want 1 0", bus.busy, bus.done);
        end
        wait_done(edges, bcyc);
        n_cmp++;
        if (edges != 32 || bus.lo !== 32'd63 || bus.hi !== 32'd0) begin
            n_err++; $display("FAIL b2b_second: edges=%0d hi=%h lo=%0d want 32 0 63", edges, bus.hi, bus.lo);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            run_check("rand", $urandom, $urandom);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_small();
        test_max();
        test_busy_inputs();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
